// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG entropy stream packer.
package jpeg_pkg;

  typedef enum logic [1:0] {
    CMD_CODE    = 2'd0,
    CMD_FLUSH   = 2'd1,
    CMD_RESTART = 2'd2
  } cmd_e;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    PAD   = 3'd1,
    DRAIN = 3'd2,
    MARK0 = 3'd3,
    MARK1 = 3'd4,
    FINAL = 3'd5
  } state_e;

  localparam logic [7:0] MARKER_FF = 8'hFF;
  localparam logic [7:0] RST_BASE  = 8'hD0;

endpackage

// File: rtl/jpeg_stream_packer_if.sv
// Code-beat input and packed-word output handshake of the stream packer.
interface jpeg_stream_packer_if #(
  parameter int OUT_W  = 16,
  parameter int CODE_W = 27
) ();

  localparam int SIZE_W  = $clog2(CODE_W + 1);
  localparam int BYTES_W = $clog2(OUT_W / 8 + 1);

  logic               ena_in;
  logic               rdy_out;
  logic [1:0]         cmd;
  logic [CODE_W-1:0]  code;
  logic [SIZE_W-1:0]  size;
  logic [OUT_W-1:0]   out;
  logic [BYTES_W-1:0] out_bytes;
  logic               ena_out;
  logic               rdy_in;

  modport master (
    output ena_in, cmd, code, size, rdy_in,
    input  rdy_out, out, out_bytes, ena_out
  );

  modport slave (
    input  ena_in, cmd, code, size, rdy_in,
    output rdy_out, out, out_bytes, ena_out
  );

endinterface

// File: rtl/jpeg_byte_packer.sv
// Collects bytes MSB-first into OUT_W-bit words behind a holding output register.
module jpeg_byte_packer #(
  parameter int OUT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             byte_vld,
  input  logic [7:0]                       byte_data,
  output logic                             byte_rdy,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic [OUT_W-1:0]                 out,
  output logic [$clog2(OUT_W/8+1)-1:0]     out_bytes,
  output logic                             ena_out,
  input  logic                             rdy_in
);

  localparam int NB    = OUT_W / 8;
  localparam int CNT_W = $clog2(NB + 1);

  logic [OUT_W-1:0] word_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [OUT_W-1:0] out_p2;
  logic [CNT_W-1:0] bytes_p2;
  logic             vld_p2;

  logic out_free;
  logic take;
  logic full;
  logic part_emit;

  assign out_free   = !vld_p2 || rdy_in;
  assign byte_rdy   = (cnt_p1 != CNT_W'(NB - 1)) || out_free;
  assign take       = byte_vld && byte_rdy;
  assign full       = take && (cnt_p1 == CNT_W'(NB - 1));
  assign part_emit  = flush_req && (cnt_p1 != '0) && out_free;
  assign flush_done = flush_req && ((cnt_p1 == '0) || out_free);

  assign out       = out_p2;
  assign out_bytes = bytes_p2;
  assign ena_out   = vld_p2;

  // Word assembly stage
  always_ff @(posedge clk) begin
    if (take) word_p1 <= {word_p1[OUT_W-9:0], byte_data};
  end

  // Output register stage: reload may coincide with the downstream clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p1   <= '0;
      vld_p2   <= 1'b0;
      out_p2   <= '0;
      bytes_p2 <= '0;
    end else begin
      if (take)           cnt_p1 <= full ? '0 : cnt_p1 + CNT_W'(1);
      else if (part_emit) cnt_p1 <= '0;

      if (full) begin
        out_p2   <= {word_p1[OUT_W-9:0], byte_data};
        bytes_p2 <= CNT_W'(NB);
        vld_p2   <= 1'b1;
      end else if (part_emit) begin
        // Left-justify the partial word; vacated low bytes fill with zeros
        out_p2   <= word_p1 << {(CNT_W'(NB) - cnt_p1), 3'b000};
        bytes_p2 <= cnt_p1;
        vld_p2   <= 1'b1;
      end else if (rdy_in) begin
        vld_p2   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jpeg_stream_packer.sv
// Bit accumulator, 0xFF byte stuffing and flush/restart-marker sequencing.
module jpeg_stream_packer
  import jpeg_pkg::*;
#(
  parameter int OUT_W    = 16,
  parameter int CODE_W   = 27,
  parameter int STUFF_EN = 1,
  parameter int ACC_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  jpeg_stream_packer_if.slave  bus
);

  localparam int SIZE_W = $clog2(CODE_W + 1);
  localparam int FILL_W = $clog2(ACC_W + 1);

  function automatic logic [CODE_W-1:0] mask_code(input logic [CODE_W-1:0] c,
                                                  input logic [SIZE_W-1:0] n);
    logic [CODE_W-1:0] r;
    for (int i = 0; i < CODE_W; i++) r[i] = c[i] && (i < int'(n));
    return r;
  endfunction

  state_e            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n, acc_x, app_bits, keep;
  logic [FILL_W-1:0] fill, fill_n, fill_x, app_len;
  logic              rdy_q, rdy_n;
  logic              stuff_pend, stuff_n;
  logic              restart_q, restart_n;
  logic [2:0]        mark_idx, mark_n;
  logic [7:0]        byte_p0, byte_n;
  logic              vld_p0, vld_n;

  logic              byte_rdy, flush_req, flush_done;
  logic              beat_take, beat_ctl, beat_code, load_ok, ext;
  logic [7:0]        top_byte;
  logic [SIZE_W-1:0] size_eff;

  assign size_eff  = (bus.size > SIZE_W'(CODE_W)) ? SIZE_W'(CODE_W) : bus.size;
  assign beat_take = bus.ena_in && rdy_q;
  assign beat_ctl  = beat_take && ((bus.cmd == CMD_FLUSH) || (bus.cmd == CMD_RESTART));
  assign beat_code = beat_take && !beat_ctl;
  assign load_ok   = !vld_p0 || byte_rdy;
  assign ext       = load_ok && !stuff_pend && (fill >= FILL_W'(8));
  assign top_byte  = acc[ACC_W-1 -: 8];
  assign bus.rdy_out = rdy_q;

  // Accumulator: valid bits are MSB-aligned, new bits land just below them
  always_comb begin
    acc_x    = ext ? (acc << 8) : acc;
    fill_x   = ext ? (fill - FILL_W'(8)) : fill;
    app_len  = '0;
    app_bits = '0;
    if (beat_code) begin
      app_len  = FILL_W'(size_eff);
      app_bits = ACC_W'(mask_code(bus.code, size_eff));
    end else if ((state == PAD) && (fill[2:0] != 3'd0)) begin
      app_len  = FILL_W'(4'd8 - {1'b0, fill[2:0]});
      app_bits = ACC_W'(8'hFF >> fill[2:0]);
    end
    keep   = ~({ACC_W{1'b1}} >> fill_x);
    acc_n  = (acc_x & keep) | (app_bits << (FILL_W'(ACC_W) - fill_x - app_len));
    fill_n = fill_x + app_len;
  end

  // Byte stage: a pending stuff byte wins over data, markers only reach it once drained
  always_comb begin
    byte_n  = byte_p0;
    vld_n   = vld_p0;
    stuff_n = stuff_pend;
    if (load_ok) begin
      if (stuff_pend) begin
        byte_n  = 8'h00;
        vld_n   = 1'b1;
        stuff_n = 1'b0;
      end else if (ext) begin
        byte_n  = top_byte;
        vld_n   = 1'b1;
        stuff_n = (STUFF_EN != 0) && (top_byte == MARKER_FF);
      end else if (state == MARK0) begin
        byte_n  = MARKER_FF;
        vld_n   = 1'b1;
      end else if (state == MARK1) begin
        byte_n  = RST_BASE + {5'b00000, mark_idx};
        vld_n   = 1'b1;
      end else begin
        vld_n   = 1'b0;
      end
    end
  end

  always_comb begin
    state_n   = state;
    mark_n    = mark_idx;
    restart_n = restart_q;
    flush_req = 1'b0;
    case (state)
      RUN: begin
        if (beat_ctl) begin
          restart_n = (bus.cmd == CMD_RESTART);
          state_n   = (fill[2:0] != 3'd0) ? PAD : DRAIN;
        end
      end
      PAD:   state_n = DRAIN;
      DRAIN: begin
        if ((fill == '0) && !stuff_pend && !vld_p0)
          state_n = restart_q ? MARK0 : FINAL;
      end
      MARK0: if (load_ok) state_n = MARK1;
      MARK1: begin
        if (load_ok) begin
          mark_n  = mark_idx + 3'd1;
          state_n = RUN;
        end
      end
      FINAL: begin
        flush_req = 1'b1;
        if (flush_done) begin
          mark_n  = 3'd0;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
    rdy_n = (state_n == RUN) && (fill_n <= FILL_W'(ACC_W - CODE_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      fill       <= '0;
      rdy_q      <= 1'b0;
      stuff_pend <= 1'b0;
      restart_q  <= 1'b0;
      mark_idx   <= 3'd0;
      vld_p0     <= 1'b0;
    end else begin
      state      <= state_n;
      fill       <= fill_n;
      rdy_q      <= rdy_n;
      stuff_pend <= stuff_n;
      restart_q  <= restart_n;
      mark_idx   <= mark_n;
      vld_p0     <= vld_n;
    end
  end

  always_ff @(posedge clk) begin
    acc     <= acc_n;
    byte_p0 <= byte_n;
  end

  jpeg_byte_packer #(.OUT_W(OUT_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_vld   (vld_p0),
    .byte_data  (byte_p0),
    .byte_rdy   (byte_rdy),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .out        (bus.out),
    .out_bytes  (bus.out_bytes),
    .ena_out    (bus.ena_out),
    .rdy_in     (bus.rdy_in)
  );

endmodule
